stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port load_valid  in  1  append load_data to the program store this cycle.
REQ-005 SHALL have port load_data  in  4  program nibble: opcode or operand.
REQ-006 SHALL have port load_clr  in  1  clear the program length to 0.
REQ-007 SHALL have port start  in  1  single-cycle pulse that begins program execution.
REQ-008 SHALL have port abort  in  1  stop execution and return to IDLE.
REQ-009 SHALL have port cpu_inbits  out  4  nibble driven onto the stack CPU inbits.
REQ-010 SHALL have port cpu_rst  out  1  reset to the stack CPU.
REQ-011 SHALL have port busy  out  1  high in every state except IDLE and HALT.
REQ-012 SHALL have port done  out  1  high while in HALT.
REQ-013 SHALL have port err  out  1  sticky error flag: truncated operand or load overflow.
REQ-014 SHALL have port pc  out  4  index of the current program nibble.
REQ-015 SHALL have port prog_len  out  5  number of loaded nibbles, 0..16.

Function
REQ-016 SHALL store the program in a 16x4 store; load_valid in IDLE or HALT writes store[prog_len] and increments prog_len.
REQ-017 SHALL ignore load_valid when prog_len==16 and set err; no wrap-around.
REQ-018 SHALL ignore load_valid and load_clr while busy; in IDLE/HALT, load_clr has priority over a same-cycle load_valid.
REQ-019 SHALL use the states IDLE, RSTCPU, FETCH, EXEC and HALT.
REQ-020 IDLE: on start go to RSTCPU; if prog_len==0, go straight to HALT instead.
REQ-021 IDLE and HALT: drive cpu_inbits=0 (NOOP) and cpu_rst=0.
REQ-022 RSTCPU (exactly 1 cycle): assert cpu_rst=1, clear pc and err, then go to FETCH.
REQ-023 FETCH (exactly 1 cycle): drive cpu_inbits=store[pc] and latch it as cur_op, then go to EXEC.
REQ-024 EXEC: hold for exec_len(cur_op) cycles.
 - 1 cycle: OUTL 3, OUTH 4, CLFL b, and NOOP (0, e, f).
 - 2 cycles: PUSH 1, POP 2, SWAP 5, PUSF 6, REPL 7, BINA 8.
 - 3 cycles: MULT 9, IDIV a, SAVE c, LOAD d.
REQ-025 Operand opcodes (1, 6, 7, 8): drive store[pc+1] on every EXEC cycle, then advance pc by 2.
REQ-026 All other opcodes: drive 0 during EXEC, then advance pc by 1.
REQ-027 If an operand opcode sits at pc==prog_len-1: drive operand 0, set err, and finish the instruction normally.
REQ-028 After the last EXEC cycle: go to FETCH if the new pc < prog_len, else go to HALT.
REQ-029 HALT: on start go to RSTCPU (rerun the program); cpu_rst=0 so CPU outputs persist.
REQ-030 abort in any state except IDLE: go to IDLE next cycle; abort takes priority over start.
REQ-031 start while busy SHALL be ignored.
REQ-032 pc arithmetic SHALL be 5-bit internally, with no wrap past 16.

Reset
REQ-033 On rst: state=IDLE, pc=0, prog_len=0, err=0, cur_op=0, cpu_inbits=0, cpu_rst=1, busy=0, done=0.
REQ-034 cpu_rst SHALL follow rst combinationally OR the RSTCPU state, so the CPU is reset whenever the sequencer is.
REQ-035 rst mid-execution SHALL abandon the instruction and clear prog_len; store contents need not be cleared.

Structure
REQ-036 A shared package SHALL hold the opcode constants, the exec_len table, the operand-opcode set and the state encoding.
REQ-037 The program store SHALL be one sub-module, seq_prog_mem: 16x4, one write port, two combinational read ports (pc, pc+1).

Verification
REQ-038 Load 1,5,3 then start -> cpu_rst high 1 cycle; cpu_inbits sequence 1,5,5,3,0; done after 5 cycles; pc=3.
REQ-039 Load 9 then start -> cpu_inbits 9,0,0,0; done; err=0.
REQ-040 Load 8 only then start -> cpu_inbits 8,0,0; err=1; done.
REQ-041 Load 17 nibbles -> prog_len=16; err=1; the 17th nibble is not stored.
REQ-042 Abort during MULT EXEC -> IDLE next cycle; busy=0; cpu_inbits=0; a following start reruns from pc=0.
REQ-043 Start with prog_len=0 -> HALT next cycle; cpu_rst stays 0; done=1.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack CPU program sequencer: opcode values,
// state encoding and the per-opcode execute-length / operand tables.
package stack_sequencer_pkg;

    localparam int unsigned PROG_DEPTH = 16;
    localparam logic [4:0]  PROG_FULL  = 5'd16;

    localparam logic [3:0] OP_NOOP = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_OUTL = 4'h3;
    localparam logic [3:0] OP_OUTH = 4'h4;
    localparam logic [3:0] OP_SWAP = 4'h5;
    localparam logic [3:0] OP_PUSF = 4'h6;
    localparam logic [3:0] OP_REPL = 4'h7;
    localparam logic [3:0] OP_BINA = 4'h8;
    localparam logic [3:0] OP_MULT = 4'h9;
    localparam logic [3:0] OP_IDIV = 4'ha;
    localparam logic [3:0] OP_CLFL = 4'hb;
    localparam logic [3:0] OP_SAVE = 4'hc;
    localparam logic [3:0] OP_LOAD = 4'hd;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RSTCPU = 3'd1,
        ST_FETCH  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Number of EXEC cycles the CPU needs for an opcode.
    function automatic logic [1:0] exec_len(input logic [3:0] op);
        case (op)
            OP_PUSH, OP_POP, OP_SWAP, OP_PUSF, OP_REPL, OP_BINA: exec_len = 2'd2;
            OP_MULT, OP_IDIV, OP_SAVE, OP_LOAD:                  exec_len = 2'd3;
            default:                                             exec_len = 2'd1;
        endcase
    endfunction

    // Opcodes followed by an operand nibble in the program.
    function automatic logic has_operand(input logic [3:0] op);
        has_operand = (op == OP_PUSH) || (op == OP_PUSF) ||
                      (op == OP_REPL) || (op == OP_BINA);
    endfunction

endpackage

// File: rtl/stack_sequencer_prog_mem.sv
// 16x4 program store: one write port, two combinational read ports so the
// opcode and its operand can be looked up in the same cycle.
module seq_prog_mem
    import stack_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [3:0] waddr_i,
    input  logic [3:0] wdata_i,
    input  logic [3:0] raddr0_i,
    input  logic [3:0] raddr1_i,
    output logic [3:0] rdata0_o,
    output logic [3:0] rdata1_o
);

    logic [3:0] mem_q [PROG_DEPTH];

    // Write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/stack_sequencer.sv
// Program sequencer that feeds a stored nibble program into a stack CPU:
// resets the CPU, then fetches each opcode, holds it for its execute time
// with any operand, and halts at the end of the program.
module stack_sequencer
    import stack_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [3:0] load_data,
    input  logic       load_clr,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] cpu_inbits,
    output logic       cpu_rst,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] pc,
    output logic [4:0] prog_len
);

    state_t     state_q;
    logic [4:0] pc_q;
    logic [4:0] prog_len_q;
    logic [3:0] cur_op_q;
    logic [1:0] cnt_q;
    logic       err_q;

    logic [3:0] rd_op;
    logic [3:0] rd_arg;
    logic [3:0] arg_addr;
    logic       idle_or_halt;
    logic       load_ok;
    logic       do_write;
    logic       arg_present;
    logic [4:0] pc_d;

    assign idle_or_halt = (state_q == ST_IDLE) || (state_q == ST_HALT);
    assign load_ok      = idle_or_halt && load_valid && !load_clr;
    assign do_write     = load_ok && (prog_len_q != PROG_FULL);
    assign arg_present  = (pc_q + 5'd1) < prog_len_q;
    assign arg_addr     = pc_q[3:0] + 4'd1;

    seq_prog_mem u_mem (
        .clk      (clk),
        .we_i     (do_write),
        .waddr_i  (prog_len_q[3:0]),
        .wdata_i  (load_data),
        .raddr0_i (pc_q[3:0]),
        .raddr1_i (arg_addr),
        .rdata0_o (rd_op),
        .rdata1_o (rd_arg)
    );

    // pc after the current instruction, saturated at 16 so it never wraps.
    always_comb begin
        pc_d = pc_q + (has_operand(cur_op_q) ? 5'd2 : 5'd1);
        if (pc_d > PROG_FULL) begin
            pc_d = PROG_FULL;
        end
    end

    // Program length: loads and clears only while the CPU is not running.
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_len_q <= 5'd0;
        end else if (idle_or_halt) begin
            if (load_clr) begin
                prog_len_q <= 5'd0;
            end else if (do_write) begin
                prog_len_q <= prog_len_q + 5'd1;
            end
        end
    end

    // Sequencer FSM: abort wins over everything except reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= 5'd0;
            err_q    <= 1'b0;
            cur_op_q <= OP_NOOP;
            cnt_q    <= 2'd0;
        end else begin
            if (load_ok && (prog_len_q == PROG_FULL)) begin
                err_q <= 1'b1;
            end
            if (abort && (state_q != ST_IDLE)) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE, ST_HALT: begin
                        if (start) begin
                            state_q <= (prog_len_q == 5'd0) ? ST_HALT : ST_RSTCPU;
                        end
                    end
                    ST_RSTCPU: begin
                        pc_q    <= 5'd0;
                        err_q   <= 1'b0;
                        state_q <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        cur_op_q <= rd_op;
                        cnt_q    <= exec_len(rd_op) - 2'd1;
                        state_q  <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        // An operand opcode in the last slot has no operand to send.
                        if (has_operand(cur_op_q) && !arg_present) begin
                            err_q <= 1'b1;
                        end
                        if (cnt_q == 2'd0) begin
                            pc_q    <= pc_d;
                            state_q <= (pc_d < prog_len_q) ? ST_FETCH : ST_HALT;
                        end else begin
                            cnt_q <= cnt_q - 2'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // CPU input nibble decoded from the registered state; NOOP outside FETCH/EXEC.
    always_comb begin
        cpu_inbits = OP_NOOP;
        if (!rst) begin
            if (state_q == ST_FETCH) begin
                cpu_inbits = rd_op;
            end else if ((state_q == ST_EXEC) && has_operand(cur_op_q) && arg_present) begin
                cpu_inbits = rd_arg;
            end
        end
    end

    assign cpu_rst  = rst || (state_q == ST_RSTCPU);
    assign busy     = !idle_or_halt;
    assign done     = (state_q == ST_HALT);
    assign err      = err_q;
    assign pc       = pc_q[3:0];
    assign prog_len = prog_len_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed scenarios plus random
// programs compared against a program-level interpreter model.
module tb_stack_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [3:0] load_data;
    logic       load_clr;
    logic       start;
    logic       abort;
    logic [3:0] cpu_inbits;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] pc;
    logic [4:0] prog_len;

    int checks   = 0;
    int failures = 0;

    int exp_bits[$];
    int exp_rst[$];
    int exp_pc;
    int exp_err;

    always #5 clk = ~clk;

    stack_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_clr   (load_clr),
        .start      (start),
        .abort      (abort),
        .cpu_inbits (cpu_inbits),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pc         (pc),
        .prog_len   (prog_len)
    );

    function automatic int ref_len(input int op);
        case (op)
            1, 2, 5, 6, 7, 8: return 2;
            9, 10, 12, 13:    return 3;
            default:          return 1;
        endcase
    endfunction

    function automatic bit ref_operand(input int op);
        return (op == 1) || (op == 6) || (op == 7) || (op == 8);
    endfunction

    // Interpret a program: per-cycle (cpu_inbits, cpu_rst) from the RSTCPU
    // cycle up to the last execute cycle, plus final pc and error flag.
    task automatic build_ref(input int prog[16], input int n);
        int p;
        int op;
        int arg;
        exp_bits.delete();
        exp_rst.delete();
        exp_bits.push_back(0);
        exp_rst.push_back(1);
        p = 0;
        exp_err = 0;
        while (p < n) begin
            op  = prog[p];
            arg = 0;
            exp_bits.push_back(op);
            exp_rst.push_back(0);
            if (ref_operand(op)) begin
                if (p + 1 < n) arg = prog[p + 1];
                else exp_err = 1;
            end
            repeat (ref_len(op)) begin
                exp_bits.push_back(arg);
                exp_rst.push_back(0);
            end
            p += ref_operand(op) ? 2 : 1;
        end
        if (p > 16) p = 16;
        exp_pc = p % 16;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_program(input int prog[16], input int n);
        load_clr = 1'b1;
        tick();
        load_clr = 1'b0;
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i][3:0];
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL reset_cpu_rst got=%0b want=1", cpu_rst);
        end
        checks++;
        if (cpu_inbits !== 4'd0) begin
            failures++;
            $display("FAIL reset_inbits got=%0h want=0", cpu_inbits);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, err, pc, prog_len, cpu_rst} !== 14'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%0b done=%0b err=%0b pc=%0d len=%0d cpu_rst=%0b want all 0",
                     busy, done, err, pc, prog_len, cpu_rst);
        end
    endtask

    task automatic test_programs();
        int prog[16];
        int n;
        for (int t = 0; t < 23; t++) begin
            for (int i = 0; i < 16; i++) prog[i] = 0;
            case (t)
                0: begin prog[0] = 1; prog[1] = 5; prog[2] = 3; n = 3; end
                1: begin prog[0] = 9; n = 1; end
                2: begin prog[0] = 8; n = 1; end
                default: begin
                    n = $urandom_range(16, 1);
                    for (int i = 0; i < n; i++) prog[i] = $urandom_range(15, 0);
                end
            endcase
            build_ref(prog, n);
            load_program(prog, n);
            @(negedge clk);
            checks++;
            if (prog_len !== n[4:0]) begin
                failures++;
                $display("FAIL prog%0d_len got=%0d want=%0d", t, prog_len, n);
            end
            pulse_start();
            for (int c = 0; c < exp_bits.size(); c++) begin
                @(negedge clk);
                checks++;
                if ({cpu_inbits, cpu_rst, busy} !== {exp_bits[c][3:0], exp_rst[c][0], 1'b1}) begin
                    failures++;
                    $display("FAIL prog%0d_cycle%0d got inbits=%0h rst=%0b busy=%0b want inbits=%0h rst=%0b busy=1",
                             t, c, cpu_inbits, cpu_rst, busy, exp_bits[c], exp_rst[c]);
                end
            end
            @(negedge clk);
            checks++;
            if ({done, busy, cpu_inbits, cpu_rst} !== {1'b1, 1'b0, 4'd0, 1'b0}) begin
                failures++;
                $display("FAIL prog%0d_halt got done=%0b busy=%0b inbits=%0h rst=%0b want 1 0 0 0",
                         t, done, busy, cpu_inbits, cpu_rst);
            end
            checks++;
            if (pc !== exp_pc[3:0] || err !== exp_err[0]) begin
                failures++;
                $display("FAIL prog%0d_end got pc=%0d err=%0b want pc=%0d err=%0b",
                         t, pc, err, exp_pc, exp_err);
            end
        end
    endtask

    task automatic test_overflow();
        int prog[16];
        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = $urandom_range(15, 0);
        prog[0] = 3;
        load_program(prog, 16);
        load_valid = 1'b1;
        load_data  = 4'd9;
        tick();
        load_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (prog_len !== 5'd16 || err !== 1'b1) begin
            failures++;
            $display("FAIL overflow got len=%0d err=%0b want len=16 err=1", prog_len, err);
        end
        pulse_start();
        @(negedge clk);
        tick();
        @(negedge clk);
        checks++;
        if (cpu_inbits !== 4'd3 || err !== 1'b0) begin
            failures++;
            $display("FAIL overflow_nowrap got inbits=%0h err=%0b want inbits=3 err=0", cpu_inbits, err);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        int prog[16];
        for (int i = 0; i < 16; i++) prog[i] = 0;
        prog[0] = 9;
        prog[1] = 3;
        do_reset();
        load_program(prog, 2);
        pulse_start();
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre busy got=%0b want=1", busy);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, cpu_inbits, cpu_rst} !== 7'd0) begin
            failures++;
            $display("FAIL abort_idle got busy=%0b done=%0b inbits=%0h rst=%0b want all 0",
                     busy, done, cpu_inbits, cpu_rst);
        end
        pulse_start();
        @(negedge clk);
        checks++;
        if (cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL abort_restart_rst got=%0b want=1", cpu_rst);
        end
        tick();
        @(negedge clk);
        checks++;
        if (pc !== 4'd0 || cpu_inbits !== 4'd9) begin
            failures++;
            $display("FAIL abort_restart got pc=%0d inbits=%0h want pc=0 inbits=9", pc, cpu_inbits);
        end
    endtask

    task automatic test_empty();
        do_reset();
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({done, busy, cpu_rst, pc} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL empty_halt got done=%0b busy=%0b cpu_rst=%0b pc=%0d want 1 0 0 0",
                     done, busy, cpu_rst, pc);
        end
    endtask

    task automatic test_busy_ignore();
        int prog[16];
        for (int i = 0; i < 16; i++) prog[i] = 0;
        prog[0] = 9;
        do_reset();
        load_program(prog, 1);
        pulse_start();
        load_clr   = 1'b1;
        load_valid = 1'b1;
        load_data  = 4'd7;
        start      = 1'b1;
        tick();
        tick();
        tick();
        load_clr   = 1'b0;
        load_valid = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        checks++;
        if (prog_len !== 5'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore got len=%0d busy=%0b want len=1 busy=1", prog_len, busy);
        end
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || pc !== 4'd1) begin
            failures++;
            $display("FAIL busy_ignore_end got done=%0b pc=%0d want done=1 pc=1", done, pc);
        end
    endtask

    task automatic test_reset_midrun();
        int prog[16];
        for (int i = 0; i < 16; i++) prog[i] = 0;
        prog[0] = 9;
        load_program(prog, 1);
        pulse_start();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, cpu_inbits, prog_len, pc} !== 15'd0) begin
            failures++;
            $display("FAIL reset_midrun got busy=%0b done=%0b inbits=%0h len=%0d pc=%0d want all 0",
                     busy, done, cpu_inbits, prog_len, pc);
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 4'd0;
        load_clr   = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        test_reset();
        test_programs();
        test_overflow();
        test_abort();
        test_empty();
        test_busy_ignore();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
